// File: rtl/mmul2_loader_if.sv
// Stream-in / operand-out bundle between a serial element source, mmul2_loader and mmul2.
// Optional frame-end checking (in_last/err) is present when MMUL2_LOADER_LAST_CHECK_EN is defined.
interface mmul2_loader_if #(
  parameter int unsigned RA = 2,
  parameter int unsigned CA = 2,
  parameter int unsigned RB = 2,
  parameter int unsigned CB = 2,
  parameter int unsigned W  = 32
);
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_data;
  logic [RA*CA*W-1:0]     A;
  logic [RB*CB*W-1:0]     B;
  logic                   enable;
  logic                   completed;
  logic                   busy;
  logic                   done;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
  logic                   in_last;
  logic                   err;
`endif

  // Source / mmul2 side of the loader
  modport master (
    output start, in_valid, in_data, completed,
    input  in_ready, A, B, enable, busy, done
`ifdef MMUL2_LOADER_LAST_CHECK_EN
    , output in_last
    , input  err
`endif
  );

  // The loader itself
  modport slave (
    input  start, in_valid, in_data, completed,
    output in_ready, A, B, enable, busy, done
`ifdef MMUL2_LOADER_LAST_CHECK_EN
    , input  in_last
    , output err
`endif
  );
endinterface

// File: rtl/mmul2_loader.sv
// mmul2_loader: collects A then B elements (row-major, one per accepted beat) into
// flattened operand buses and holds mmul2.enable until mmul2 reports completed.
// Optional feature macro: MMUL2_LOADER_LAST_CHECK_EN (in_last framing check, sticky err).
module mmul2_loader #(
  parameter int unsigned RA = 2,
  parameter int unsigned CA = 2,
  parameter int unsigned RB = 2,
  parameter int unsigned CB = 2,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mmul2_loader_if.slave bus
);

  localparam int unsigned NA   = RA * CA;
  localparam int unsigned NB   = RB * CB;
  localparam int unsigned NMAX = (NA > NB) ? NA : NB;
  localparam int unsigned IW   = $clog2(NMAX + 1);
  localparam int unsigned AW   = NA * W;
  localparam int unsigned BW   = NB * W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  // Reject shapes that cannot be multiplied
  if (CA != RB || RA == 0 || CA == 0 || RB == 0 || CB == 0 || W == 0) begin : g_bad_dims
    $error("mmul2_loader: illegal dimensions (CA must equal RB, all dimensions nonzero)");
  end

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic          in_ready_q, in_ready_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer_c;
  logic          a_last_c;
  logic          b_last_c;
  logic          frame_err_c;
  logic          err_q, err_d;

  assign xfer_c   = bus.in_valid && in_ready_q;
  assign a_last_c = (idx_q == IW'(NA - 1));
  assign b_last_c = (idx_q == IW'(NB - 1));

  // Framing error: in_last must coincide exactly with the final B beat
`ifdef MMUL2_LOADER_LAST_CHECK_EN
  assign frame_err_c = (state_q == S_LOAD_B) ? (bus.in_last != b_last_c) : bus.in_last;
`else
  assign frame_err_c = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state, element capture and registered-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD_A;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD_A: begin
        if (xfer_c) begin
          for (int unsigned e = 0; e < NA; e++) begin
            if (idx_q == IW'(e)) a_d[e*W +: W] = bus.in_data;
          end
          if (frame_err_c) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end else if (a_last_c) begin
            state_d = S_LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (xfer_c) begin
          for (int unsigned e = 0; e < NB; e++) begin
            if (idx_q == IW'(e)) b_d[e*W +: W] = bus.in_data;
          end
          if (frame_err_c) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end else if (b_last_c) begin
            state_d = S_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_RUN: begin
        if (bus.completed) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    enable_d   = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.enable   = enable_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
  assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_mmul2_loader.sv
// Bench for mmul2_loader (2x2 by 2x2, 8-bit elements): frame-level model plus
// literal checks of the packed operand buses and handshake corner cases.
module tb_mmul2_loader;

  localparam int unsigned RA = 2;
  localparam int unsigned CA = 2;
  localparam int unsigned RB = 2;
  localparam int unsigned CB = 2;
  localparam int unsigned W  = 8;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_FIN  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   en_cycles = 0;
  int   xfer_cnt  = 0;

  mmul2_loader_if #(.RA(RA), .CA(CA), .RB(RB), .CB(CB), .W(W)) bus ();

  mmul2_loader #(.RA(RA), .CA(CA), .RB(RB), .CB(CB), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Frame-level model: a load is 8 accepted beats, 4 for A then 4 for B
  int         m_phase = P_IDLE;
  int         m_beats = 0;
  logic [7:0] m_a [4] = '{default: 8'h00};
  logic [7:0] m_b [4] = '{default: 8'h00};
  bit         m_err   = 1'b0;
  bit         m_abort;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_beats = 0;
      m_err   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_a[i] = 8'h00;
        m_b[i] = 8'h00;
      end
    end else begin
      case (m_phase)
        P_IDLE: if (bus.start) begin
          m_phase = P_LOAD;
          m_beats = 0;
          m_err   = 1'b0;
        end
        P_LOAD: if (bus.in_valid) begin
          if (m_beats < 4) m_a[m_beats] = bus.in_data;
          else             m_b[m_beats-4] = bus.in_data;
          m_beats++;
          m_abort = 1'b0;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
          m_abort = (bus.in_last != (m_beats == 8));
`endif
          if (m_abort) begin
            m_err   = 1'b1;
            m_phase = P_IDLE;
          end else if (m_beats == 8) begin
            m_phase = P_RUN;
          end
        end
        P_RUN: if (bus.completed) m_phase = P_FIN;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(m_phase == P_LOAD));
    check("enable",   64'(bus.enable),   64'(m_phase == P_RUN));
    check("busy",     64'(bus.busy),     64'(m_phase != P_IDLE));
    check("done",     64'(bus.done),     64'(m_phase == P_FIN));
    check("A",        64'(bus.A),        64'({m_a[3], m_a[2], m_a[1], m_a[0]}));
    check("B",        64'(bus.B),        64'({m_b[3], m_b[2], m_b[1], m_b[0]}));
`ifdef MMUL2_LOADER_LAST_CHECK_EN
    check("err",      64'(bus.err),      64'(m_err));
`endif
    if (bus.enable) en_cycles++;
    if (bus.in_valid && bus.in_ready) xfer_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // start, then nbeats data beats base+0.. (optional gaps, start pokes, early completed)
  task automatic load_frame(input logic [7:0] base, input int nbeats, input bit gappy,
                            input bit poke, input bit comp_early, input int bad_last);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gappy) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(i);
      if (poke && i >= 4) bus.start = 1'b1;
      if (comp_early && i == 7) bus.completed = 1'b1;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
      bus.in_last = (i == 7) ^ (i == bad_last);
`else
      if (bad_last == i) bus.in_data = base + 8'(i);
`endif
      tick();
    end
    bus.in_valid = 1'b0;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
    bus.in_last  = 1'b0;
`endif
  endtask

  // Drive completed and walk RUN -> FIN -> IDLE
  task automatic finish_run(input bit early);
    if (!early) begin
      repeat (2) tick();
      bus.completed = 1'b1;
    end
    tick();
    check("done_pulse", 64'(bus.done), 64'd1);
    check("fin_enable", 64'(bus.enable), 64'd0);
    bus.completed = 1'b0;
    bus.start     = 1'b0;
    tick();
    check("post_done", 64'(bus.done), 64'd0);
    check("post_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.completed = 1'b0;
`ifdef MMUL2_LOADER_LAST_CHECK_EN
    bus.in_last   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Idle: offered data is not accepted without start
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) tick();
    check("idle_ready", 64'(bus.in_ready), 64'd0);
    check("idle_A",     64'(bus.A),        64'd0);
    check("idle_B",     64'(bus.B),        64'd0);
    check("idle_busy",  64'(bus.busy),     64'd0);
    bus.in_valid = 1'b0;
    tick();

    // Back-to-back load of 1..8
    xfer_cnt = 0;
    load_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, -1);
    check("f1_A",      64'(bus.A),        64'h04030201);
    check("f1_B",      64'(bus.B),        64'h08070605);
    check("f1_enable", 64'(bus.enable),   64'd1);
    check("f1_ready",  64'(bus.in_ready), 64'd0);
    check("f1_xfers",  64'(xfer_cnt),     64'd8);
    finish_run(1'b0);

    // Same stream with in_valid toggling
    xfer_cnt = 0;
    load_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, -1);
    check("f2_A",     64'(bus.A),    64'h04030201);
    check("f2_B",     64'(bus.B),    64'h08070605);
    check("f2_xfers", 64'(xfer_cnt), 64'd8);
    finish_run(1'b0);

    // Reset after 5 beats wipes the frame immediately
    load_frame(8'h21, 5, 1'b0, 1'b0, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check("rst_A",     64'(bus.A),        64'd0);
    check("rst_B",     64'(bus.B),        64'd0);
    check("rst_busy",  64'(bus.busy),     64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_frame(8'h10, 8, 1'b0, 1'b0, 1'b0, -1);
    check("f3_A", 64'(bus.A), 64'h13121110);
    check("f3_B", 64'(bus.B), 64'h17161514);
    finish_run(1'b0);

    // start poked during LOAD_B and RUN; completed already high on RUN entry
    en_cycles = 0;
    load_frame(8'h31, 8, 1'b0, 1'b1, 1'b1, -1);
    check("f4_A", 64'(bus.A), 64'h34333231);
    check("f4_B", 64'(bus.B), 64'h38373635);
    finish_run(1'b1);
    check("f4_en_cycles", 64'(en_cycles), 64'd1);
    tick();
    check("f4_idle", 64'(bus.busy), 64'd0);

`ifdef MMUL2_LOADER_LAST_CHECK_EN
    // Premature in_last on beat 6 aborts with sticky err
    en_cycles = 0;
    load_frame(8'h41, 8, 1'b0, 1'b0, 1'b0, 5);
    tick();
    check("lc_err",        64'(bus.err),   64'd1);
    check("lc_busy",       64'(bus.busy),  64'd0);
    check("lc_en_cycles",  64'(en_cycles), 64'd0);
    load_frame(8'h51, 8, 1'b0, 1'b0, 1'b0, -1);
    check("lc_err_clear",  64'(bus.err),   64'd0);
    check("lc_A",          64'(bus.A),     64'h54535251);
    finish_run(1'b0);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
